// File: rtl/lightcube_pkg.sv
// Shared types and constants for the light-cube frame path: source FSM states,
// display_mode encodings and cube geometry.
package lightcube_pkg;

    typedef enum logic [1:0] {
        S_DEFAULT      = 2'd0,
        S_PEND_UART    = 2'd1,
        S_UART         = 2'd2,
        S_PEND_DEFAULT = 2'd3
    } src_state_t;

    localparam logic MODE_DEFAULT = 1'b0;
    localparam logic MODE_UART    = 1'b1;

    localparam int unsigned CUBE_BYTES = 64;

endpackage

// File: rtl/frame_source_ctrl_if.sv
// Handshake bundle between the frame-source controller and its neighbours.
// force_mode exists only when SRC_FORCE_EN is defined.
interface frame_source_ctrl_if;

    logic       frame_sync;
    logic       uart_frame_done;
    logic       display_mode;
    logic       load_en;
    logic       uart_active;
    logic [1:0] state_o;
`ifdef SRC_FORCE_EN
    logic [1:0] force_mode;
`endif

    modport master (
        output frame_sync,
        output uart_frame_done,
`ifdef SRC_FORCE_EN
        output force_mode,
`endif
        input  display_mode,
        input  load_en,
        input  uart_active,
        input  state_o
    );

    modport slave (
        input  frame_sync,
        input  uart_frame_done,
`ifdef SRC_FORCE_EN
        input  force_mode,
`endif
        output display_mode,
        output load_en,
        output uart_active,
        output state_o
    );

endinterface

// File: rtl/frame_source_ctrl_silence_timer.sv
// silence_timer: saturating counter of cycles since the last completed UART
// frame; o_timeout is high while the count sits at TIMEOUT_CYCLES.
module silence_timer #(
    parameter  int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (r_count == LIMIT);

endmodule

// File: rtl/frame_source_ctrl.sv
// Selects default animation or UART frames for the frame buffer, switching and
// loading only at frame boundaries. Optional SRC_FORCE_EN adds a force_mode input.
module frame_source_ctrl
    import lightcube_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic                clk,
    input logic                rst,
    frame_source_ctrl_if.slave bus
);

    src_state_t r_state, w_state_d;
    logic       r_mode, w_mode_d;
    logic       r_load, w_load_d;
    logic       r_flag, w_flag_d;
    logic       r_active, w_active_d;
    logic       w_timeout;
    logic       w_forced;
    logic       w_fs, w_ufd;

    assign w_fs  = bus.frame_sync;
    assign w_ufd = bus.uart_frame_done;

`ifdef SRC_FORCE_EN
    assign w_forced = (bus.force_mode == 2'b01) || (bus.force_mode == 2'b10);
`else
    assign w_forced = 1'b0;
`endif

    // Counter is held cleared while a force is active so release starts fresh.
    silence_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_ufd | w_forced),
        .i_enable (r_state != S_DEFAULT),
        .o_timeout(w_timeout)
    );

    always_comb begin
        w_state_d = r_state;
        w_mode_d  = r_mode;
        w_load_d  = 1'b0;
        w_flag_d  = r_flag | w_ufd;

        case (r_state)
            S_DEFAULT: begin
                w_load_d = w_fs;
                if (w_ufd) w_state_d = S_PEND_UART;
            end
            S_PEND_UART: begin
                if (w_fs) begin
                    w_state_d = S_UART;
                    w_mode_d  = MODE_UART;
                    w_load_d  = 1'b1;
                end else if (w_timeout && !w_ufd) begin
                    w_state_d = S_DEFAULT;
                end
            end
            S_UART: begin
                w_load_d = w_fs && (r_flag || w_ufd);
                if (w_timeout && !w_ufd) w_state_d = S_PEND_DEFAULT;
            end
            S_PEND_DEFAULT: begin
                if (w_ufd) begin
                    w_state_d = S_UART;
                    w_load_d  = w_fs;
                end else if (w_fs) begin
                    w_state_d = S_DEFAULT;
                    w_mode_d  = MODE_DEFAULT;
                    w_load_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = S_DEFAULT;
                w_mode_d  = MODE_DEFAULT;
            end
        endcase

`ifdef SRC_FORCE_EN
        if (bus.force_mode == 2'b01) begin
            w_state_d = S_DEFAULT;
            w_load_d  = w_fs;
            if (w_fs) w_mode_d = MODE_DEFAULT;
        end else if (bus.force_mode == 2'b10) begin
            w_state_d = S_UART;
            w_load_d  = w_fs;
            if (w_fs) w_mode_d = MODE_UART;
        end
`endif

        if (w_load_d && (w_mode_d == MODE_UART)) w_flag_d = 1'b0;

        w_active_d = (w_state_d == S_UART) || (w_state_d == S_PEND_DEFAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_DEFAULT;
            r_mode   <= MODE_DEFAULT;
            r_load   <= 1'b0;
            r_flag   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_mode   <= w_mode_d;
            r_load   <= w_load_d;
            r_flag   <= w_flag_d;
            r_active <= w_active_d;
        end
    end

    assign bus.display_mode = r_mode;
    assign bus.load_en      = r_load;
    assign bus.uart_active  = r_active;
    assign bus.state_o      = r_state;

endmodule

// File: tb/tb_frame_source_ctrl.sv
// Bench for frame_source_ctrl: directed walk through the main scenarios, then
// randomized traffic compared against a source-selection model.
module tb_frame_source_ctrl;

    localparam int unsigned T = 100;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    frame_source_ctrl_if bus ();

    frame_source_ctrl #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: which source is shown, which one is wanted, pending-frame flag, silence.
    bit m_shown_uart;
    bit m_want_uart;
    bit m_flag;
    bit m_load;
    int m_sil;

    function automatic int model_state();
        if (!m_shown_uart) return m_want_uart ? 1 : 0;
        return m_want_uart ? 2 : 3;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit fs, input bit ufd);
        bit timeout;
        bit new_want;
        if (r) begin
            m_shown_uart = 0; m_want_uart = 0; m_flag = 0; m_load = 0; m_sil = 0;
            return;
        end
        timeout = (m_sil == T);
        if (ufd) m_sil = 0;
        else if (model_state() != 0 && m_sil < T) m_sil++;

        if (ufd) new_want = 1;
        else if (timeout && !(!m_shown_uart && m_want_uart && fs)) new_want = 0;
        else new_want = m_want_uart;

        m_load = 0;
        if (fs) begin
            if (!m_shown_uart) begin
                m_load = 1;
                if (m_want_uart) m_shown_uart = 1;
            end else if (m_want_uart || ufd) begin
                m_load = m_flag || ufd;
            end else begin
                m_load = 1;
                m_shown_uart = 0;
            end
        end
        m_flag = m_flag | ufd;
        if (m_load && m_shown_uart) m_flag = 0;
        m_want_uart = new_want;
    endtask

    task automatic step(input bit r, input bit fs, input bit ufd);
        @(negedge clk);
        rst                 = r;
        bus.frame_sync      = fs;
        bus.uart_frame_done = ufd;
        model_update(r, fs, ufd);
        @(posedge clk);
        #1;
        check_eq("display_mode", int'(bus.display_mode), int'(m_shown_uart));
        check_eq("load_en", int'(bus.load_en), int'(m_load));
        check_eq("uart_active", int'(bus.uart_active), int'(m_shown_uart));
        check_eq("state_o", int'(bus.state_o), model_state());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.frame_sync = 1'b0;
        bus.uart_frame_done = 1'b0;
`ifdef SRC_FORCE_EN
        bus.force_mode = 2'b00;
`endif
        step(1, 0, 0);
        step(1, 0, 0);
        check_eq("rst_state", int'(bus.state_o), 0);
        check_eq("rst_load", int'(bus.load_en), 0);

        // Default animation reloads every frame.
        for (int k = 0; k < 3; k++) begin
            idle(19);
            step(0, 1, 0);
            check_eq("dflt_load", int'(bus.load_en), 1);
            check_eq("dflt_mode", int'(bus.display_mode), 0);
        end

        // Switch to UART at the next boundary.
        idle(4);
        step(0, 0, 1);
        check_eq("pend_uart", int'(bus.state_o), 1);
        idle(14);
        step(0, 1, 0);
        check_eq("uart_mode", int'(bus.display_mode), 1);
        check_eq("uart_load", int'(bus.load_en), 1);
        check_eq("uart_state", int'(bus.state_o), 2);

        // Held frame, then one fresh frame.
        idle(19);
        step(0, 1, 0);
        check_eq("hold_noload", int'(bus.load_en), 0);
        step(0, 0, 1);
        idle(5);
        step(0, 1, 0);
        check_eq("fresh_load", int'(bus.load_en), 1);
        idle(19);
        step(0, 1, 0);
        check_eq("fresh_once", int'(bus.load_en), 0);

        // Silence: revert pending, then applied at the boundary.
        idle(110);
        check_eq("pend_dflt", int'(bus.state_o), 3);
        check_eq("pend_dflt_mode", int'(bus.display_mode), 1);
        step(0, 1, 0);
        check_eq("revert_mode", int'(bus.display_mode), 0);
        check_eq("revert_load", int'(bus.load_en), 1);
        check_eq("revert_state", int'(bus.state_o), 0);

        // Cancel the pending revert with a simultaneous frame and boundary.
        step(0, 0, 1);
        idle(3);
        step(0, 1, 0);
        idle(110);
        check_eq("pend_dflt2", int'(bus.state_o), 3);
        step(0, 1, 1);
        check_eq("cancel_state", int'(bus.state_o), 2);
        check_eq("cancel_mode", int'(bus.display_mode), 1);
        check_eq("cancel_load", int'(bus.load_en), 1);

        // Reset while a switch is pending.
        idle(130);
        step(0, 1, 0);
        step(0, 0, 1);
        check_eq("pre_rst_state", int'(bus.state_o), 1);
        step(1, 0, 0);
        check_eq("rst_mid_state", int'(bus.state_o), 0);
        check_eq("rst_mid_active", int'(bus.uart_active), 0);
        step(0, 1, 0);
        check_eq("post_rst_load", int'(bus.load_en), 1);
        check_eq("post_rst_mode", int'(bus.display_mode), 0);

        // Randomized phases with varying UART density so timeouts occur.
        for (int ph = 0; ph < 20; ph++) begin
            int ufd_rate;
            int fs_rate;
            ufd_rate = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 40 : 6);
            fs_rate  = 8 + int'($urandom_range(0, 20));
            for (int c = 0; c < 400; c++) begin
                bit r;
                bit fs;
                bit ufd;
                r   = ($urandom_range(0, 999) == 0);
                fs  = ($urandom_range(0, fs_rate - 1) == 0);
                ufd = (ufd_rate != 0) && ($urandom_range(0, ufd_rate - 1) == 0);
                step(r, fs, ufd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
